// File: rtl/asin_pkg.sv
// asin_pkg: shared FSM encoding and fixed sizes for the arcsine search
package asin_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, READ, CMP, DONE} state_t;
  localparam int ITERS = 9;
  localparam int DEPTH = 257;
  localparam logic [7:0] MID = 8'd128;
endpackage

// File: rtl/asin_search_if.sv
// asin_search_if: request/result handshake between a client and asin_search
interface asin_search_if;
  logic       start;
  logic [7:0] y_in;
  logic       busy;
  logic       done;
  logic [9:0] x_out;
  modport master (output start, y_in, input busy, done, x_out);
  modport slave (input start, y_in, output busy, done, x_out);
endinterface

// File: rtl/sine_quarter_rom.sv
// sine_quarter_rom: first-quarter sine magnitudes q[k] = round(127*sin(2*pi*k/1024)), registered read
module sine_quarter_rom
  import asin_pkg::*;
(
  input  logic       clk,
  input  logic [8:0] addr,
  output logic [6:0] data
);
  function automatic logic [6:0] q_of(int k);
    real r;
    r = 127.0 * $sin(2.0 * 3.14159265358979 * k / 1024.0);
    return 7'($rtoi(r + 0.5));
  endfunction
  logic [6:0] tbl [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
    assign tbl[i] = q_of(i);
  end
  // one-cycle read; addresses past the quarter saturate at full scale
  always_ff @(posedge clk) begin
    data <= (addr < 9'(DEPTH)) ? tbl[addr] : 7'd127;
  end
endmodule

// File: rtl/asin_search.sv
// asin_search: fixed-latency binary search of the quarter sine table to recover phase from a sample
// Optional ASIN_SEARCH_SIGNED_EN maps negative samples to angles 768..1023.
module asin_search
  import asin_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  asin_search_if.slave bus
);
  state_t     state, state_n;
  logic       acc;
  logic [6:0] m;
  logic [8:0] lo, hi, lo_n, hi_n, mid;
  logic [9:0] sum;
  logic [3:0] cnt, cnt_n;
  logic [9:0] x;
  logic [6:0] q;
  logic [7:0] dif;
  logic       accept;
`ifdef ASIN_SEARCH_SIGNED_EN
  logic       neg;
`endif
  assign accept = (state == IDLE) && bus.start && !acc;
  assign dif = (bus.y_in >= MID) ? bus.y_in - MID : MID - bus.y_in;
  assign sum = {1'b0, lo} + {1'b0, hi};
  assign mid = sum[9:1];
  assign cnt_n = cnt + 4'd1;
  assign lo_n = (lo == hi) ? lo : ((q >= m) ? lo : mid + 9'd1);
  assign hi_n = (lo == hi) ? hi : ((q >= m) ? mid : hi);
  assign bus.x_out = x;
  sine_quarter_rom u_rom (.clk(clk), .addr(mid), .data(q));
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // next state: the accepted request is taken one edge later, then 9 read/compare pairs
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = acc ? LOAD : IDLE;
      LOAD: state_n = READ;
      READ: state_n = CMP;
      CMP:  state_n = (cnt_n < 4'(ITERS)) ? READ : DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // status outputs decoded from the current state
  always_comb begin
    bus.busy = (state == LOAD) || (state == READ) || (state == CMP);
    bus.done = (state == DONE);
  end
  // datapath: capture magnitude, narrow [lo,hi], publish the result on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 1'b0;
      m <= '0;
      lo <= '0;
      hi <= '0;
      cnt <= '0;
      x <= '0;
`ifdef ASIN_SEARCH_SIGNED_EN
      neg <= 1'b0;
`endif
    end else begin
      acc <= accept;
      if (accept) m <= (dif > 8'd127) ? 7'd127 : dif[6:0];
`ifdef ASIN_SEARCH_SIGNED_EN
      if (accept) neg <= (bus.y_in < MID);
`endif
      if (state == LOAD) begin
        lo <= '0;
        hi <= 9'(DEPTH - 1);
        cnt <= '0;
      end
      if (state == CMP) begin
        lo <= lo_n;
        hi <= hi_n;
        cnt <= cnt_n;
      end
`ifdef ASIN_SEARCH_SIGNED_EN
      if (state == CMP && state_n == DONE) x <= neg ? 10'd0 - {1'b0, lo_n} : {1'b0, lo_n};
`else
      if (state == CMP && state_n == DONE) x <= {1'b0, lo_n};
`endif
    end
  end
endmodule

// File: tb/tb_asin_search.sv
// tb_asin_search: randomized and directed checks of asin_search against a table-scan model
module tb_asin_search;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  asin_search_if bus ();
  asin_search dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int qt [257];
  int checks = 0;
  int errors = 0;
  int cyc, acc, exp_x, pend, d;
  bit active;
  bit lit_en = 1'b0, rt_en = 1'b0;
  int lit_x = 0, rt_y = 0;
  function automatic int rnd(real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction
  function automatic int sine(int xv);
    return 128 + rnd(127.0 * $sin(2.0 * 3.14159265358979 * xv / 1024.0));
  endfunction
  function automatic int ref_x(int y);
    int mg, k;
    mg = (y >= 128) ? y - 128 : 128 - y;
    if (mg > 127) mg = 127;
    k = 256;
    for (int i = 256; i >= 0; i--) if (qt[i] >= mg) k = i;
`ifdef ASIN_SEARCH_SIGNED_EN
    return (y < 128) ? (1024 - k) % 1024 : k;
`else
    return k;
`endif
  endfunction
  initial for (int i = 0; i < 257; i++) qt[i] = rnd(127.0 * $sin(2.0 * 3.14159265358979 * i / 1024.0));
  // cycle model: a search accepted at edge a shows busy after edges a+1..a+19, done after a+20
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      acc <= 0;
      active <= 1'b0;
      exp_x <= 0;
      pend <= 0;
    end else begin
      cyc <= cyc + 1;
      if (active && cyc + 1 - acc == 20) exp_x <= pend;
      if (bus.start && (!active || cyc + 1 - acc >= 22)) begin
        active <= 1'b1;
        acc <= cyc + 1;
        pend <= ref_x(int'(bus.y_in));
      end
    end
  end
  task automatic chk(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d want %0d", n, cyc, got, want);
    end
  endtask
  // single compare point, half a cycle after each active edge
  always @(negedge clk) begin
    d = cyc - acc;
    chk("busy", int'(bus.busy), int'(active && d >= 1 && d <= 19));
    chk("done", int'(bus.done), int'(active && d == 20));
    chk("x_out", int'(bus.x_out), exp_x);
    if (bus.done && lit_en) chk("x_literal", int'(bus.x_out), lit_x);
    if (bus.done && rt_en) chk("round_trip_y", sine(int'(bus.x_out)), rt_y);
  end
  task automatic wait_done();
    for (int i = 0; i < 30 && !bus.done; i++) @(negedge clk);
    if (!bus.done) begin
      $display("FAIL done_timeout at edge %0d: got no done want done within 30 edges", cyc);
      $fatal(1);
    end
  endtask
  task automatic pulse(input logic [7:0] y, input int want, input bit lit, input bit rt);
    @(posedge clk);
    #2;
    lit_en = lit;
    lit_x = want;
    rt_en = rt;
    rt_y = int'(y);
    bus.start = 1'b1;
    bus.y_in = y;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
  endtask
  task automatic run(input logic [7:0] y, input int want, input bit lit, input bit rt);
    pulse(y, want, lit, rt);
    wait_done();
  endtask
  initial begin
    bus.start = 1'b0;
    bus.y_in = 8'd0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    run(8'd128, 0, 1'b1, 1'b0);
    run(8'd255, 242, 1'b1, 1'b0);
    run(8'd192, 86, 1'b1, 1'b0);
`ifdef ASIN_SEARCH_SIGNED_EN
    run(8'd64, 938, 1'b1, 1'b0);
    run(8'd0, 782, 1'b1, 1'b0);
`else
    run(8'd64, 86, 1'b1, 1'b0);
    run(8'd0, 242, 1'b1, 1'b0);
`endif
    pulse(8'd255, 242, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    bus.start = 1'b1;
    bus.y_in = 8'd150;
    @(posedge clk);
    #2 bus.start = 1'b0;
    wait_done();
    pulse(8'd200, 0, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    run(8'd192, 86, 1'b1, 1'b0);
    lit_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      bus.start = 1'b1;
      bus.y_in = 8'($urandom);
    end
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      bus.start = ($urandom_range(0, 3) == 0);
      bus.y_in = 8'($urandom);
    end
    bus.start = 1'b0;
    repeat (25) @(posedge clk);
    for (int xv = 0; xv <= 256; xv++) run(8'(sine(xv)), 0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/asin_search.md
ASIN_SEARCH -- requirements
Module: asin_search

Interface
REQ-001 The block SHALL have these ports, in this order: clk  in  1  single clock, all state on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 start  in  1  request pulse; sampled on rising edge, accepted only in IDLE.
REQ-004 y_in  in  8  offset-binary sine sample (128 = zero, 255 = +full scale, 0 = -full scale), sampled on the accepting edge.
REQ-005 busy  out  1  high while a search is in progress (LOAD/READ/CMP).
REQ-006 done  out  1  one-cycle pulse marking x_out valid.
REQ-007 x_out  out  10  recovered phase, same 1024-step-per-period scale as sine_func x; held from done until the next done.
REQ-008 The block SHALL have one parameter: none; all sizes are fixed constants.

Function
REQ-009 Magnitude m SHALL be |y_in - 128|, clamped to 127 (y_in=0 gives m=127).
REQ-010 Quarter table q[k] SHALL equal round(127*sin(2*pi*k/1024)) for k=0..256, unsigned 7-bit, monotonic non-decreasing.
REQ-011 The result index k SHALL be the smallest k in 0..256 with q[k] >= m.
REQ-012 Search SHALL be binary: lo=0, hi=256; each iteration mid=(lo+hi)>>1; if q[mid]>=m then hi=mid, else lo=mid+1; when lo==hi the iteration SHALL leave lo/hi unchanged.
REQ-013 Exactly 9 iterations SHALL run, regardless of data, giving a fixed latency.
REQ-014 States SHALL be IDLE, LOAD, READ, CMP, DONE: IDLE->LOAD on start; LOAD->READ; READ->CMP; CMP->READ while iteration count < 9, else CMP->DONE; DONE->IDLE.
REQ-015 The ROM SHALL be read synchronously: address presented in READ, data used in CMP.
REQ-016 done SHALL be high exactly in the cycle DONE is registered, 20 rising edges after the accepting edge; x_out SHALL update on that same edge.
REQ-017 start SHALL be ignored while busy or in DONE; no queueing.
REQ-018 start held high continuously SHALL begin a new search on each return to IDLE.
REQ-019 busy SHALL rise on the edge after acceptance and fall on the edge entering DONE.

Reset
REQ-020 On rst_n low, state SHALL go to IDLE immediately; busy=0, done=0, x_out=0, lo/hi/iteration count=0.
REQ-021 Reset mid-search SHALL abandon the search with no done pulse; the first start after release SHALL run a full 20-edge search.

Configuration
REQ-022 Macro ASIN_SEARCH_SIGNED_EN: when defined, y_in<128 SHALL give x_out=(1024-k) mod 1024 (negative angle, 768..1023) and y_in>=128 SHALL give x_out=k.
REQ-023 When ASIN_SEARCH_SIGNED_EN is undefined, x_out SHALL be k zero-extended for all y_in (magnitude angle 0..256 only).

Structure
REQ-024 Package asin_pkg SHALL hold the state encoding, the iteration count (9), the quarter-table depth (257), and the mid-scale constant (128).
REQ-025 Sub-module sine_quarter_rom SHALL hold q[], with a 9-bit address, 7-bit data, and a one-cycle registered read.

Verification
REQ-026 y_in=128, start pulse -> done at edge 20 after acceptance, x_out=0, busy high for edges 1..19.
REQ-027 y_in=255 -> x_out=242; y_in=192 -> x_out=86 (both builds).
REQ-028 With ASIN_SEARCH_SIGNED_EN: y_in=64 -> x_out=938; y_in=0 -> x_out=782. Without the macro: y_in=64 -> x_out=86; y_in=0 -> x_out=242.
REQ-029 Sweep: drive sine_func with x=0..256 and feed each y into asin_search -> each x_out decodes back to the same y via sine_func (round-trip equality of y, not x).
REQ-030 start re-pulsed at edge 5 of a search -> ignored, single done at edge 20; rst_n low at edge 10 -> no done, outputs 0; the next start completes normally.
